// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the core's data-memory responder:
// MMIO window base/offsets, byte-lane select codes and lane-merge helper.
package mem_map_pkg;

    localparam int          NUM_LANES     = 4;
    localparam int          LANE_W        = 8;
    localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;

    localparam logic [3:0] OFF_GPIO  = 4'h0;
    localparam logic [3:0] OFF_CYCLE = 4'h4;
    localparam logic [3:0] OFF_STCNT = 4'h8;
    localparam logic [3:0] OFF_ERR   = 4'hC;

    // sel[3] qualifies data[31:24] (big-endian byte offset 0)
    localparam logic [3:0] SEL_BYTE0   = 4'b1000;
    localparam logic [3:0] SEL_BYTE1   = 4'b0100;
    localparam logic [3:0] SEL_BYTE2   = 4'b0010;
    localparam logic [3:0] SEL_BYTE3   = 4'b0001;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        REG_GPIO  = 2'd0,
        REG_CYCLE = 2'd1,
        REG_STCNT = 2'd2,
        REG_ERR   = 2'd3
    } mmio_reg_e;

    typedef struct packed {
        logic ram;
        logic mmio;
        logic oor;
    } dec_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < NUM_LANES; k++)
            if (sel[k]) res[k*LANE_W +: LANE_W] = wdata[k*LANE_W +: LANE_W];
        return res;
    endfunction

endpackage

// File: rtl/data_ram_resp_byte_ram.sv
// One 8-bit lane of the data RAM: synchronous write, asynchronous read.
module byte_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: 4-lane byte RAM plus MMIO window (GPIO, cycle
// counter, store counter, sticky error), with zero-latency load data.
module data_ram_resp
    import mem_map_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [31:0] gpio_o,
    output logic        err_o
);

    dec_t                              dec;
    mmio_reg_e                         mreg;
    logic                              access;
    logic                              is_load;
    logic                              is_store;
    logic                              ram_store;
    logic                              mmio_store;
    logic [ADDR_W-1:0]                 word_addr;
    logic [NUM_LANES-1:0]              lane_we;
    logic [NUM_LANES-1:0][LANE_W-1:0]  ram_rdata;
    logic [31:0]                       gpio_q;
    logic [31:0]                       cyc_q;
    logic [31:0]                       stcnt_q;
    logic                              err_q;
    logic [31:0]                       rd_mux;
    logic                              unused_addr;

    assign access    = |ce_i;
    assign is_load   = access & ~we_i;
    // Gating with rst_n drops a store whose edge falls inside a reset pulse.
    assign is_store  = access & we_i & rst_n;
    assign word_addr = addr_i[ADDR_W+1:2];
    assign mreg      = mmio_reg_e'(addr_i[3:2]);
    assign unused_addr = ^addr_i[1:0];

    always_comb begin
        dec.ram  = (addr_i[31:ADDR_W+2] == '0);
        dec.mmio = (addr_i[31:4] == MMIO_BASE[31:4]);
        dec.oor  = access & ~dec.ram & ~dec.mmio;
    end

    assign ram_store  = is_store & dec.ram  & (|sel_i);
    assign mmio_store = is_store & dec.mmio & (|sel_i);
    assign lane_we    = {NUM_LANES{is_store & dec.ram}} & sel_i;

    byte_ram #(.ADDR_W(ADDR_W)) u_lane [NUM_LANES-1:0] (
        .clk   (clk),
        .we    (lane_we),
        .addr  (word_addr),
        .wdata (data_i),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gpio_q <= '0;
        else if (mmio_store && mreg == REG_GPIO)
            gpio_q <= lane_merge(gpio_q, data_i, sel_i);
    end

    // A store to the counter replaces the increment for that cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc_q <= '0;
        else if (mmio_store && mreg == REG_CYCLE)
            cyc_q <= lane_merge(cyc_q, data_i, sel_i);
        else
            cyc_q <= cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stcnt_q <= '0;
        else if (ram_store && stcnt_q != 32'hFFFF_FFFF)
            stcnt_q <= stcnt_q + 32'd1;
    end

    // Set has priority over the software clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (dec.oor)
            err_q <= 1'b1;
        else if (mmio_store && mreg == REG_ERR && sel_i[0] && data_i[0])
            err_q <= 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        if (dec.ram) begin
            rd_mux = ram_rdata;
        end else if (dec.mmio) begin
            case (mreg)
                REG_GPIO:  rd_mux = gpio_q;
                REG_CYCLE: rd_mux = cyc_q;
                REG_STCNT: rd_mux = stcnt_q;
                REG_ERR:   rd_mux = {31'b0, err_q};
                default:   rd_mux = '0;
            endcase
        end
    end

    assign data_o = (is_load && rst_n) ? rd_mux : 32'h0;
    assign gpio_o = gpio_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: vector table plus counter-wrap and
// mid-store reset sequences.
module tb_data_ram_resp;
    import mem_map_pkg::*;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ce_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [31:0] gpio_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    data_ram_resp #(.ADDR_W(12), .MMIO_BASE(MB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .gpio_o (gpio_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [31:0] exp_gpio;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ce, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata);
        ce_i = ce; we_i = we; addr_i = addr; sel_i = sel; data_i = wdata;
    endtask

    task automatic add(input string n, input logic [3:0] ce, input logic we,
                       input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata,
                       input logic [31:0] ed, input logic [31:0] eg, input logic ee);
        vec_t v;
        v.name = n; v.ce = ce; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
        v.exp_data = ed; v.exp_gpio = eg; v.exp_err = ee;
        vq.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_exp [4];
        wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;

        //   name            ce     we    addr          sel      wdata         exp_data      exp_gpio      err
        add("st_word",      4'hF, 1'b1, 32'h10,       SEL_WORD,  32'h1234_5678, 32'h0,        32'h0,        1'b0);
        add("ld_word",      4'hF, 1'b0, 32'h10,       SEL_WORD,  32'h0,         32'h1234_5678, 32'h0,       1'b0);
        add("st_byte",      4'hF, 1'b1, 32'h11,       SEL_BYTE0, 32'hAA00_0000, 32'h0,        32'h0,        1'b0);
        add("ld_sel0",      4'h1, 1'b0, 32'h10,       4'b0000,   32'h0,         32'hAA34_5678, 32'h0,       1'b0);
        add("st_half",      4'hF, 1'b1, 32'h12,       SEL_HALF_LO, 32'h0000_BEEF, 32'h0,      32'h0,        1'b0);
        add("ld_half",      4'hF, 1'b0, 32'h10,       SEL_WORD,  32'h0,         32'hAA34_BEEF, 32'h0,       1'b0);
        add("ld_stcnt3",    4'hF, 1'b0, MB + 32'h8,   SEL_WORD,  32'h0,         32'h3,        32'h0,        1'b0);
        add("st_word0",     4'hF, 1'b1, 32'h0,        SEL_WORD,  32'hCAFE_F00D, 32'h0,        32'h0,        1'b0);
        add("st_oor",       4'hF, 1'b1, 32'h0001_0000, SEL_WORD, 32'h5555_5555, 32'h0,        32'h0,        1'b0);
        add("ld_alias",     4'hF, 1'b0, 32'h0,        SEL_WORD,  32'h0,         32'hCAFE_F00D, 32'h0,       1'b1);
        add("ld_errreg",    4'hF, 1'b0, MB + 32'hC,   SEL_WORD,  32'h0,         32'h1,        32'h0,        1'b1);
        add("clr_err",      4'hF, 1'b1, MB + 32'hC,   SEL_BYTE3, 32'h1,         32'h0,        32'h0,        1'b1);
        add("ld_errclr",    4'hF, 1'b0, MB + 32'hC,   SEL_WORD,  32'h0,         32'h0,        32'h0,        1'b0);
        add("ld_oor",       4'hF, 1'b0, 32'h2000_0000, SEL_WORD, 32'h0,         32'h0,        32'h0,        1'b0);
        add("ld_stcnt4",    4'hF, 1'b0, MB + 32'h8,   SEL_WORD,  32'h0,         32'h4,        32'h0,        1'b1);
        add("clr_badsel",   4'hF, 1'b1, MB + 32'hC,   SEL_BYTE2, 32'h1,         32'h0,        32'h0,        1'b1);
        add("clr_baddat",   4'hF, 1'b1, MB + 32'hC,   SEL_BYTE3, 32'h0,         32'h0,        32'h0,        1'b1);
        add("ld_errkeep",   4'hF, 1'b0, MB + 32'hC,   SEL_WORD,  32'h0,         32'h1,        32'h0,        1'b1);
        add("clr_err2",     4'hF, 1'b1, MB + 32'hC,   SEL_WORD,  32'h1,         32'h0,        32'h0,        1'b1);
        add("st_gpio",      4'hF, 1'b1, MB,           SEL_WORD,  32'hDEAD_BEEF, 32'h0,        32'h0,        1'b0);
        add("st_gpio_b",    4'hF, 1'b1, MB,           SEL_BYTE3, 32'h0000_0012, 32'h0,        32'hDEAD_BEEF, 1'b0);
        add("ld_gpio",      4'hF, 1'b0, MB,           SEL_WORD,  32'h0,         32'hDEAD_BE12, 32'hDEAD_BE12, 1'b0);
        add("ce0_st",       4'h0, 1'b1, 32'h10,       SEL_WORD,  32'h0,         32'h0,        32'hDEAD_BE12, 1'b0);
        add("ce0_ld",       4'h0, 1'b0, 32'h10,       SEL_WORD,  32'h0,         32'h0,        32'hDEAD_BE12, 1'b0);
        add("st_sel0",      4'hF, 1'b1, 32'h10,       4'b0000,   32'h0,         32'h0,        32'hDEAD_BE12, 1'b0);
        add("ld_after",     4'h2, 1'b0, 32'h10,       SEL_WORD,  32'h0,         32'hAA34_BEEF, 32'hDEAD_BE12, 1'b0);
        add("ld_stcnt_k",   4'hF, 1'b0, MB + 32'h8,   SEL_WORD,  32'h0,         32'h4,        32'hDEAD_BE12, 1'b0);
        add("st_stcnt",     4'hF, 1'b1, MB + 32'h8,   SEL_WORD,  32'h0,         32'h0,        32'hDEAD_BE12, 1'b0);
        add("ld_stcnt_ig",  4'hF, 1'b0, MB + 32'h8,   SEL_WORD,  32'h0,         32'h4,        32'hDEAD_BE12, 1'b0);
        add("st_top",       4'hF, 1'b1, 32'h3FFC,     SEL_WORD,  32'h0BAD_C0DE, 32'h0,        32'hDEAD_BE12, 1'b0);
        add("ld_top",       4'hF, 1'b0, 32'h3FFC,     SEL_WORD,  32'h0,         32'h0BAD_C0DE, 32'hDEAD_BE12, 1'b0);
        add("ld_past_top",  4'hF, 1'b0, 32'h4000,     SEL_WORD,  32'h0,         32'h0,        32'hDEAD_BE12, 1'b0);
        add("ld_stcnt5",    4'hF, 1'b0, MB + 32'h8,   SEL_WORD,  32'h0,         32'h5,        32'hDEAD_BE12, 1'b1);

        // Reset state, with a load presented while reset is held.
        drive(4'hF, 1'b0, 32'h10, SEL_WORD, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_o, 32'h0);
        check("rst_gpio", gpio_o, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'h0);
        rst_n = 1'b1;
        drive(4'hF, 1'b0, MB + 32'h4, SEL_WORD, 32'h0);
        @(negedge clk);
        check("rst_cycle", data_o, 32'h0);
        next_cycle();
        @(negedge clk);
        check("cycle_inc", data_o, 32'h1);
        next_cycle();
        drive(4'hF, 1'b0, MB + 32'h8, SEL_WORD, 32'h0);
        @(negedge clk);
        check("rst_stcnt", data_o, 32'h0);
        next_cycle();

        foreach (vq[i]) begin
            drive(vq[i].ce, vq[i].we, vq[i].addr, vq[i].sel, vq[i].wdata);
            @(negedge clk);
            check({vq[i].name, "_data"}, data_o, vq[i].exp_data);
            check({vq[i].name, "_gpio"}, gpio_o, vq[i].exp_gpio);
            check({vq[i].name, "_err"}, {31'b0, err_o}, {31'b0, vq[i].exp_err});
            next_cycle();
        end

        // Cycle counter wrap, then partial-lane load of the counter.
        drive(4'hF, 1'b1, MB + 32'h4, SEL_WORD, 32'hFFFF_FFFE);
        next_cycle();
        drive(4'hF, 1'b0, MB + 32'h4, SEL_WORD, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("wrap%0d", i), data_o, wrap_exp[i]);
            next_cycle();
        end
        drive(4'hF, 1'b1, MB + 32'h4, SEL_HALF_HI, 32'hABCD_0000);
        next_cycle();
        drive(4'hF, 1'b0, MB + 32'h4, SEL_WORD, 32'h0);
        @(negedge clk);
        check("cyc_part", data_o, 32'hABCD_0002);
        next_cycle();
        @(negedge clk);
        check("cyc_part_inc", data_o, 32'hABCD_0003);
        next_cycle();

        // Reset pulse in the middle of a RAM store.
        drive(4'hF, 1'b1, 32'h10, SEL_WORD, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gpio", gpio_o, 32'h0);
        check("mid_rst_err", {31'b0, err_o}, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        drive(4'hF, 1'b0, MB + 32'h4, SEL_WORD, 32'h0);
        @(negedge clk);
        check("mid_rst_cycle", data_o, 32'h0);
        next_cycle();
        drive(4'hF, 1'b0, MB + 32'h8, SEL_WORD, 32'h0);
        @(negedge clk);
        check("mid_rst_stcnt", data_o, 32'h0);
        next_cycle();
        drive(4'hF, 1'b0, 32'h10, SEL_WORD, 32'h0);
        @(negedge clk);
        check("mid_rst_lost", data_o, 32'hAA34_BEEF);
        check("mid_rst_word0", gpio_o, 32'h0);
        next_cycle();
        drive(4'hF, 1'b0, 32'h0, SEL_WORD, 32'h0);
        @(negedge clk);
        check("mid_rst_keep", data_o, 32'hCAFE_F00D);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
